// File: rtl/hazard3_regfile_mwnr_pkg.sv
// Shared types, constants and predicates for the multi-write / multi-read register file.
// Optional same-cycle write-to-read bypass is selected with HAZARD3_REGFILE_BYPASS_EN.
package hazard3_regfile_mwnr_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  localparam int unsigned MAX_RPORTS = 4;
  localparam int unsigned MAX_WPORTS = 2;

  // True when an address names a real, writable/readable register.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned n_regs,
                                   input bit zero_reg0);
    return (addr < n_regs) && !(zero_reg0 && (addr == 0));
  endfunction

endpackage

// File: rtl/hazard3_regfile_rport.sv
// One registered read port: address masking, optional bypass, output register with hold.
// Bypass from this cycle's writes is compiled in with HAZARD3_REGFILE_BYPASS_EN.
module hazard3_regfile_rport
  import hazard3_regfile_mwnr_pkg::*;
#(
  parameter int unsigned N_REGS    = 32,
  parameter int unsigned W_DATA    = 32,
  parameter int unsigned N_WPORTS  = 1,
  parameter bit          ZERO_REG0 = 1'b1,
  parameter int unsigned W_ADDR    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_busy,
  input  logic                         ren,
  input  logic [W_ADDR-1:0]            raddr,
  input  logic [W_DATA-1:0]            mem_data,
  input  logic [N_WPORTS-1:0]          wr_en,
  input  logic [N_WPORTS*W_ADDR-1:0]   waddr,
  input  logic [N_WPORTS*W_DATA-1:0]   wdata,
  output logic [W_DATA-1:0]            rdata
);

  logic [W_DATA-1:0] rdata_q, rdata_d, sel_data;

  always_comb begin
    sel_data = mem_data;
`ifdef HAZARD3_REGFILE_BYPASS_EN
    // wr_en already excludes dropped writes and clear cycles; later port wins.
    for (int w = 0; w < N_WPORTS; w++) begin
      if (wr_en[w] && (waddr[w*W_ADDR +: W_ADDR] == raddr)) begin
        sel_data = wdata[w*W_DATA +: W_DATA];
      end
    end
`endif
    rdata_d = addr_ok(32'(raddr), N_REGS, ZERO_REG0) ? sel_data : '0;
  end

`ifndef HAZARD3_REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, waddr, wdata};
`endif

  always_ff @(posedge clk) begin
    if (rst || clear_busy) begin
      rdata_q <= '0;
    end else if (ren) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hazard3_regfile_mwnr.sv
// Register file with N write / N read ports, post-reset clear sequencer and registered reads.
// Define HAZARD3_REGFILE_BYPASS_EN to forward same-cycle write data to colliding reads.
module hazard3_regfile_mwnr
  import hazard3_regfile_mwnr_pkg::*;
#(
  parameter int unsigned N_REGS         = 32,
  parameter int unsigned W_DATA         = 32,
  parameter int unsigned N_RPORTS       = 2,
  parameter int unsigned N_WPORTS       = 1,
  parameter bit          ZERO_REG0      = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned W_ADDR        = $clog2(N_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_RPORTS-1:0]          ren,
  input  logic [N_RPORTS*W_ADDR-1:0]   raddr,
  output logic [N_RPORTS*W_DATA-1:0]   rdata,
  input  logic [N_WPORTS-1:0]          wen,
  input  logic [N_WPORTS*W_ADDR-1:0]   waddr,
  input  logic [N_WPORTS*W_DATA-1:0]   wdata,
  output logic                         clear_busy
);

  state_e            state_q, state_d;
  logic [W_ADDR-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StRun;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + W_ADDR'(1);
        if (clr_idx_q == W_ADDR'(N_REGS - 1)) begin
          state_d   = StRun;
          clr_idx_d = '0;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    clear_busy = (state_q == StClear);
  end

  // Effective write strobes: dropped writes and clear cycles never reach mem or bypass.
  logic [N_WPORTS-1:0] wr_en;

  always_comb begin
    wr_en = '0;
    for (int w = 0; w < N_WPORTS; w++) begin
      wr_en[w] = wen[w] && !clear_busy &&
                 addr_ok(32'(waddr[w*W_ADDR +: W_ADDR]), N_REGS, ZERO_REG0);
    end
  end

  logic [W_DATA-1:0] mem [N_REGS];

  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge clk) begin
    if (clear_busy) begin
      mem[clr_idx_q] <= '0;
    end
    for (int w = 0; w < N_WPORTS; w++) begin
      if (wr_en[w]) begin
        mem[waddr[w*W_ADDR +: W_ADDR]] <= wdata[w*W_DATA +: W_DATA];
      end
    end
  end

  for (genvar p = 0; p < N_RPORTS; p++) begin : g_rport
    logic [W_ADDR-1:0] ra;
    logic [W_DATA-1:0] mem_rd;

    assign ra     = raddr[p*W_ADDR +: W_ADDR];
    assign mem_rd = (32'(ra) < N_REGS) ? mem[ra] : '0;

    hazard3_regfile_rport #(
      .N_REGS    (N_REGS),
      .W_DATA    (W_DATA),
      .N_WPORTS  (N_WPORTS),
      .ZERO_REG0 (ZERO_REG0),
      .W_ADDR    (W_ADDR)
    ) u_rport (
      .clk        (clk),
      .rst        (rst),
      .clear_busy (clear_busy),
      .ren        (ren[p]),
      .raddr      (ra),
      .mem_data   (mem_rd),
      .wr_en      (wr_en),
      .waddr      (waddr),
      .wdata      (wdata),
      .rdata      (rdata[p*W_DATA +: W_DATA])
    );
  end

endmodule

// File: tb/tb_hazard3_regfile_mwnr.sv
// Scoreboard bench for hazard3_regfile_mwnr: N_REGS=20, two read and two write ports.
// Expected bypass behaviour follows HAZARD3_REGFILE_BYPASS_EN.
module tb_hazard3_regfile_mwnr;

  localparam int unsigned NR = 20;
  localparam int unsigned WA = 5;
`ifdef HAZARD3_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    ren;
  logic [2*WA-1:0] raddr;
  logic [63:0]   rdata;
  logic [1:0]    wen;
  logic [2*WA-1:0] waddr;
  logic [63:0]   wdata;
  logic          clear_busy;

  hazard3_regfile_mwnr #(
    .N_REGS         (NR),
    .W_DATA         (32),
    .N_RPORTS       (2),
    .N_WPORTS       (2),
    .ZERO_REG0      (1'b1),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ren        (ren),
    .raddr      (raddr),
    .rdata      (rdata),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .clear_busy (clear_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic cyc(input string nm, input logic r, input logic [1:0] re,
                     input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] we,
                     input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [31:0] e0, input logic [31:0] e1, input logic busy);
    exp_t e;
    @(negedge clk);
    rst   = r;
    ren   = re;
    raddr = {ra1, ra0};
    wen   = we;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    e.busy = busy;
    e.e0   = e0;
    e.e1   = e1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one scoreboard entry per driven cycle, checked just after its edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (rdata[31:0] !== e.e0) begin
          bad++;
          $display("FAIL %s rdata0 got %h want %h", nm, rdata[31:0], e.e0);
        end
        total++;
        if (rdata[63:32] !== e.e1) begin
          bad++;
          $display("FAIL %s rdata1 got %h want %h", nm, rdata[63:32], e.e1);
        end
        total++;
        if (clear_busy !== e.busy) begin
          bad++;
          $display("FAIL %s clear_busy got %b want %b", nm, clear_busy, e.busy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0;

    // 1: reset, clear sequence of NR cycles, writes ignored, all regs read zero.
    cyc("rst", 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < int'(NR) - 1; i++)
      cyc("clr", 0, 2'b11, 3, 4, 2'b11, 3, 4, 32'h55, 32'h66, 0, 0, 1);
    cyc("clr_end", 0, 2'b11, 3, 4, 2'b11, 3, 4, 32'h55, 32'h66, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc("rd_all", 0, 2'b11, 5'(i), 5'(i + 10), 2'b00, 0, 0, 0, 0, 0, 0, 0);

    // 2: write, read on both ports, hold, independent port hold.
    cyc("wr5", 0, 2'b00, 0, 0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc("rd5", 0, 2'b11, 5, 5, 2'b00, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    cyc("hold", 0, 2'b00, 1, 1, 2'b00, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    cyc("wr6_p1", 0, 2'b00, 0, 0, 2'b10, 0, 6, 0, 32'h600D, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    cyc("rd6_p0", 0, 2'b01, 6, 0, 2'b00, 0, 0, 0, 0, 32'h600D, 32'hDEADBEEF, 0);

    // 3: reg 0 hardwired to zero.
    cyc("wr0", 0, 2'b00, 0, 0, 2'b01, 0, 0, 32'h1234, 0, 32'h600D, 32'hDEADBEEF, 0);
    cyc("rd0", 0, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    // 4: same-address dual write, port 1 wins.
    cyc("wr7", 0, 2'b00, 0, 0, 2'b11, 7, 7, 32'h11, 32'h22, 0, 0, 0);
    cyc("rd7", 0, 2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 32'h22, 32'h22, 0);

    // 5: read/write collision, single and dual writer.
    cyc("wr9", 0, 2'b00, 0, 0, 2'b01, 9, 0, 32'hAA, 0, 32'h22, 32'h22, 0);
    cyc("byp9", 0, 2'b11, 9, 9, 2'b01, 9, 0, 32'hBB, 0,
        BYP ? 32'hBB : 32'hAA, BYP ? 32'hBB : 32'hAA, 0);
    cyc("rd9", 0, 2'b11, 9, 9, 2'b00, 0, 0, 0, 0, 32'hBB, 32'hBB, 0);
    cyc("byp8", 0, 2'b11, 8, 8, 2'b11, 8, 8, 32'h33, 32'h44,
        BYP ? 32'h44 : 32'h0, BYP ? 32'h44 : 32'h0, 0);
    cyc("rd8", 0, 2'b11, 8, 8, 2'b00, 0, 0, 0, 0, 32'h44, 32'h44, 0);
    cyc("byp0", 0, 2'b11, 0, 0, 2'b01, 0, 0, 32'h99, 0, 0, 0, 0);

    // Out-of-range addresses: reads zero, writes dropped without aliasing.
    cyc("wr25", 0, 2'b00, 0, 0, 2'b11, 25, 25, 32'h77, 32'h78, 0, 0, 0);
    cyc("byp25", 0, 2'b11, 25, 25, 2'b01, 25, 0, 32'h79, 0, 0, 0, 0);
    cyc("rd25", 0, 2'b11, 25, 25, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    cyc("alias", 0, 2'b11, 5, 9, 2'b00, 0, 0, 0, 0, 32'hDEADBEEF, 32'hBB, 0);

    // 6: reset from RUN, then a reset mid-clear at idx=10 restarts the full sequence.
    cyc("rst2", 1, 2'b11, 5, 9, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      cyc("clr2a", 0, 2'b11, 5, 9, 2'b11, 5, 9, 32'h1, 32'h2, 0, 0, 1);
    cyc("rst_mid", 1, 2'b11, 5, 9, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < int'(NR) - 1; i++)
      cyc("clr2b", 0, 2'b11, 5, 9, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    cyc("clr2_end", 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    cyc("rd_post", 0, 2'b11, 5, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle", 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
